// File: rtl/moore_seq_detect_n_if.sv
// rtl/moore_seq_detect_n_if.sv - stream, control and status bundle for the pattern detector
interface moore_seq_detect_n_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic          x;
  logic          x_valid;
  logic          overlap;
  logic          load;
  logic [N-1:0]  pattern;
  logic          clear;
  logic          z;
  logic [CW-1:0] match_count;
  logic          count_sat;

  modport master (
    output x, x_valid, overlap, load, pattern, clear,
    input  z, match_count, count_sat
  );

  modport slave (
    input  x, x_valid, overlap, load, pattern, clear,
    output z, match_count, count_sat
  );
endinterface

// File: rtl/moore_seq_detect_n.sv
// rtl/moore_seq_detect_n.sv - Moore serial pattern detector with loadable pattern and saturating match counter
module moore_seq_detect_n #(
  parameter int           N            = 4,
  parameter logic [N-1:0] PATTERN_INIT = 4'b1001,
  parameter int           CW           = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  moore_seq_detect_n_if.slave  bus
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pat_q, pat_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q;
  logic          match_ev;

  // Moore output: only a full window of real bits equal to the pattern is a match
  always_comb begin
    z_q = (fill_q == FILL_FULL) && (hist_q == pat_q);
  end

  // Next-state: load restarts detection and drops any same-cycle bit; clear beats a match
  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    match_ev = 1'b0;

    if (bus.load) begin
      pat_d  = bus.pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.x_valid) begin
      hist_d = {hist_q[N-2:0], bus.x};
      if (!bus.overlap && z_q)
        fill_d = FW'(1);
      else if (fill_q == FILL_FULL)
        fill_d = FILL_FULL;
      else
        fill_d = fill_q + FW'(1);
      match_ev = (fill_d == FILL_FULL) && (hist_d == pat_q);
    end

    if (bus.clear)
      cnt_d = '0;
    else if (match_ev && !(&cnt_q))
      cnt_d = cnt_q + CW'(1);
  end

  // State register with asynchronous reset that discards any partial match
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= PATTERN_INIT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.z           = z_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = &cnt_q;

endmodule

// File: tb/tb_moore_seq_detect_n.sv
// tb/tb_moore_seq_detect_n.sv - directed self-checking bench for moore_seq_detect_n
module tb_moore_seq_detect_n;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  moore_seq_detect_n_if #(.N(4), .CW(8)) bi0 ();
  moore_seq_detect_n_if #(.N(4), .CW(2)) bi1 ();

  moore_seq_detect_n #(.N(4), .PATTERN_INIT(4'b1001), .CW(8)) u0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bi0.slave)
  );

  moore_seq_detect_n #(.N(4), .PATTERN_INIT(4'b1001), .CW(2)) u1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bi1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bit0(input logic b);
    bi0.x = b;
    bi0.x_valid = 1'b1;
    tick();
    bi0.x_valid = 1'b0;
  endtask

  task automatic bit1(input logic b);
    bi1.x = b;
    bi1.x_valid = 1'b1;
    tick();
    bi1.x_valid = 1'b0;
  endtask

  task automatic load0(input logic [3:0] p, input logic clr);
    bi0.pattern = p;
    bi0.load = 1'b1;
    bi0.clear = clr;
    tick();
    bi0.load = 1'b0;
    bi0.clear = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] z7;

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bi0.x = 0; bi0.x_valid = 0; bi0.overlap = 1; bi0.load = 0; bi0.pattern = '0; bi0.clear = 0;
    bi1.x = 0; bi1.x_valid = 0; bi1.overlap = 1; bi1.load = 0; bi1.pattern = '0; bi1.clear = 0;
    tick();
    tick();
    chk("rst_z0", int'(bi0.z), 0);
    chk("rst_cnt0", int'(bi0.match_count), 0);
    chk("rst_sat0", int'(bi0.count_sat), 0);
    chk("rst_cnt1", int'(bi1.match_count), 0);
    reset_n = 1'b1;
    tick();

    // overlapping 1001 on 1,0,0,1,0,0,1
    s7 = 7'b1001001;
    z7 = 7'b0001001;
    bi0.overlap = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      bit0(s7[i]);
      chk($sformatf("ovl_z_bit%0d", 7 - i), int'(bi0.z), int'(z7[i]));
    end
    chk("ovl_cnt", int'(bi0.match_count), 2);

    // load together with clear restarts and zeroes the count
    load0(4'b1001, 1'b1);
    chk("ldclr_z", int'(bi0.z), 0);
    chk("ldclr_cnt", int'(bi0.match_count), 0);

    // non-overlapping on the same stream
    bi0.overlap = 1'b0;
    z7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      bit0(s7[i]);
      chk($sformatf("novl_z_bit%0d", 7 - i), int'(bi0.z), int'(z7[i]));
    end
    chk("novl_cnt", int'(bi0.match_count), 1);
    chk("novl_fill", int'(u0.fill_q), 3);

    // gapped stream: z holds through idle cycles
    load0(4'b1001, 1'b0);
    chk("gap_cnt_kept", int'(bi0.match_count), 1);
    bi0.overlap = 1'b1;
    s7 = 7'b0001001;
    for (int i = 3; i >= 0; i--) begin
      bit0(s7[i]);
      chk($sformatf("gap_z_bit%0d", 4 - i), int'(bi0.z), (i == 0) ? 1 : 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("gap_idle_z_bit%0d_%0d", 4 - i, k), int'(bi0.z), (i == 0) ? 1 : 0);
      end
    end
    chk("gap_cnt", int'(bi0.match_count), 2);
    bit0(1'b0);
    chk("gap_z_after", int'(bi0.z), 0);

    // all-zeros pattern needs four real zeros
    load0(4'b0000, 1'b1);
    chk("zero_cnt_clr", int'(bi0.match_count), 0);
    for (int i = 1; i <= 3; i++) begin
      bit0(1'b0);
      chk($sformatf("zero_z_bit%0d", i), int'(bi0.z), 0);
      chk($sformatf("zero_cnt_bit%0d", i), int'(bi0.match_count), 0);
    end
    for (int i = 4; i <= 6; i++) begin
      bit0(1'b0);
      chk($sformatf("zero_z_bit%0d", i), int'(bi0.z), 1);
      chk($sformatf("zero_cnt_bit%0d", i), int'(bi0.match_count), i - 3);
    end

    // load during a partial match drops the same-cycle bit
    load0(4'b0110, 1'b0);
    chk("ld_z", int'(bi0.z), 0);
    bit0(1'b0);
    bit0(1'b1);
    bit0(1'b1);
    chk("part_z", int'(bi0.z), 0);
    bi0.x = 1'b0;
    bi0.x_valid = 1'b1;
    load0(4'b0110, 1'b0);
    bi0.x_valid = 1'b0;
    chk("ldx_fill", int'(u0.fill_q), 0);
    chk("ldx_cnt", int'(bi0.match_count), 3);
    bit0(1'b0);
    chk("ldx_fill1", int'(u0.fill_q), 1);
    bit0(1'b1);
    bit0(1'b1);
    chk("ldx_z3", int'(bi0.z), 0);
    bit0(1'b0);
    chk("ldx_z4", int'(bi0.z), 1);
    chk("ldx_cnt4", int'(bi0.match_count), 4);

    // CW=2 saturation on pattern 1111
    bi1.pattern = 4'b1111;
    bi1.load = 1'b1;
    tick();
    bi1.load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bit1(1'b1);
      chk($sformatf("sat_cnt_bit%0d", i), int'(bi1.match_count), (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3));
      chk($sformatf("sat_flag_bit%0d", i), int'(bi1.count_sat), (i >= 6) ? 1 : 0);
    end
    bi1.clear = 1'b1;
    bit1(1'b1);
    bi1.clear = 1'b0;
    chk("clr_match_cnt", int'(bi1.match_count), 0);
    chk("clr_match_z", int'(bi1.z), 1);
    chk("clr_match_sat", int'(bi1.count_sat), 0);
    bit1(1'b1);
    chk("post_clr_cnt", int'(bi1.match_count), 1);

    // asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_z1", int'(bi1.z), 0);
    chk("arst_cnt1", int'(bi1.match_count), 0);
    chk("arst_z0", int'(bi0.z), 0);
    chk("arst_cnt0", int'(bi0.match_count), 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore_seq_detect_n.md
Name: moore_seq_detect_n

Overview:
- Parametrised Moore-style serial pattern detector. It replaces fixed 3-flop sequence detectors in the lab datapath.
- Watches a qualified single-bit stream for a runtime-loadable N-bit pattern, first-received bit = pattern MSB.
- Supports overlapping and non-overlapping detection, plus a saturating match counter.
- Sits between the serial input synchroniser and the status/LED logic.

Parameters:
- N, 4: pattern length in bits; legal range 2..16.
- PATTERN_INIT, 4'b1001: pattern loaded at reset; N bits wide.
- CW, 8: match counter width in bits.

Ports:
- clock, input, 1: sole clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- x, input, 1: serial data bit.
- x_valid, input, 1: x is sampled only when high; gaps are allowed.
- overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping; sampled every accepted bit.
- load, input, 1: single-cycle strobe that captures `pattern` and restarts detection.
- pattern, input, N: new pattern value, used only when load=1.
- clear, input, 1: synchronous clear of match_count.
- z, output, 1: Moore match output, decoded from state only.
- match_count, output, CW: number of matches, saturating.
- count_sat, output, 1: high while match_count is at all-ones.

Behaviour:
- State: pat_q[N-1:0], hist[N-1:0] (shift register), fill (0..N, width clog2(N+1)), match_count.
- Reset (reset_n=0, async):
  - pat_q=PATTERN_INIT, hist=0, fill=0, match_count=0.
  - Therefore z=0 and count_sat=0.
  - Reset asserted mid-stream discards any partial match immediately.
- Accepted bit (x_valid=1, load=0):
  - hist <= {hist[N-2:0], x}.
  - fill <= (fill==N) ? N : fill+1.
  - Exception: if overlap=0 and z=1 in the current cycle, fill <= 1. The incoming bit becomes the first bit of the next candidate.
- z = (fill==N) && (hist==pat_q).
  - Purely a function of registered state; no combinational path from x.
  - Latency: z rises in the cycle after the edge that accepted the final pattern bit.
  - z holds while x_valid=0 (state unchanged).
- Match event: an accepted bit whose next state satisfies the z condition.
  - Consecutive overlapping matches (e.g. pattern 1111 with stream of 1s) keep z high continuously. Each accepted bit still counts as a separate match.
- match_count:
  - +1 per match event.
  - Saturates at 2^CW-1; no wrap.
  - count_sat = (match_count == all-ones).
- load=1:
  - pat_q <= pattern, hist <= 0, fill <= 0.
  - z is 0 on the next cycle.
  - match_count is unaffected.
  - load takes priority over x_valid: a bit presented in the same cycle is discarded and not counted.
- clear=1:
  - match_count <= 0.
  - If a match event occurs in the same cycle, clear wins and the count is 0.
  - Detection state is unaffected.
- overlap changing mid-stream takes effect on the next accepted bit; no state flush.
- Simultaneous load and clear: both actions apply.
- Only fill==N can produce a match, so no false match can arise from reset zeros in hist (e.g. pattern 0000 needs N real accepted zeros).

Test Plan:
- N=4, pattern 1001, overlap=1, x_valid=1 every cycle, stream 1,0,0,1,0,0,1 → z high the cycle after bits 4 and 7 (1-indexed), low otherwise; match_count=2.
- Same stream with overlap=0 → z high only after bit 4; match_count=1; fill=3 after bit 7.
- Stream 1,0,0,1 with x_valid low for 3 cycles between each bit → single match; z stays high through the idle cycles after bit 4 until the next accepted bit.
- Pattern 0000, stream 0,0,0 after reset → z=0, count=0. A fourth 0 → z=1, count=1. Further 0s with overlap=1 → count increments each bit, z stays 1.
- load=1 with pattern=0110 while hist holds 3 partial bits and x_valid=1 in the same cycle → bit dropped. Then stream 0,1,1,0 → one match; prior count preserved.
- CW=2: drive 5 matches → count stops at 3, count_sat=1. Then clear coincident with a match → count=0. Then assert reset_n=0 asynchronously mid-cycle → z and count drop to 0 without waiting for a clock edge.
